ahb_apb_bridge: RTL and testbench
=================================

Name: ahb_apb_bridge

Overview:
AHB-Lite slave that converts single AHB transfers into APB3 accesses for the peripheral region. It sits beside the SRAM and default slaves: it is selected by the decoder's HSEL_APB and returns hrdata_apb, hready_apb and hresp_apb into the AHB response mux. On the APB side it is the sole APB master. It inserts AHB wait states while the APB access runs, maps PSLVERR and timeouts to a two-cycle AHB ERROR, and rejects unsupported HSIZE.

Parameters:
ADDR_WIDTH, 32, AHB address width
DATA_WIDTH, 32, AHB/APB data width
APB_ADDR_WIDTH, 16, PADDR width; PADDR = HADDR[APB_ADDR_WIDTH-1:0]
TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout

Ports:
HCLK  in  1  AHB clock; all state on rising edge
HRESETn  in  1  asynchronous active-low reset
HSEL_APB  in  1  decoder select for the APB region
HADDR  in  ADDR_WIDTH  address-phase address
HTRANS  in  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size
HWDATA  in  DATA_WIDTH  write data, valid in the data phase
HREADY  in  1  bus-level HREADY (mux output)
hrdata_apb  out  DATA_WIDTH  read data to the response mux
hready_apb  out  1  slave ready to the response mux
hresp_apb  out  2  00 OKAY, 01 ERROR
PADDR  out  APB_ADDR_WIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Clock and reset: one clock, HCLK; asynchronous active-low reset, HRESETn.
- Reset state: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, hrdata_apb=0, hready_apb=1, hresp_apb=00, timeout counter=0.
- Accept condition: accept = HSEL_APB & HTRANS[1] & HREADY, sampled only in IDLE, DONE or ERR2. On accept, register HADDR, HWRITE and HSIZE.
- Size check: if the accepted HSIZE > 3'b010, go to ERR1 and issue no APB access.
- States:
  - IDLE: hready_apb=1, hresp_apb=00. Accepted write goes to WDATA; accepted read goes to SETUP.
  - WDATA: hready_apb=0. Capture HWDATA into PWDATA, then go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, PADDR and PWRITE from the registered values, hready_apb=0. Go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, hready_apb=0, counter increments each cycle.
    - PREADY & !PSLVERR: go to DONE; on a read, register PRDATA into hrdata_apb.
    - PREADY & PSLVERR: go to ERR1.
    - TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES with PREADY=0: go to ERR1.
  - Leaving ACCESS: PSEL and PENABLE drop to 0, counter clears.
  - DONE: hready_apb=1, hresp_apb=00. Accept allowed (back-to-back), else go to IDLE.
  - ERR1: hready_apb=0, hresp_apb=01. Go to ERR2.
  - ERR2: hready_apb=1, hresp_apb=01. Accept allowed, else go to IDLE.
- Output stability: PADDR, PWRITE and PWDATA hold constant from SETUP through the last ACCESS cycle. hrdata_apb holds its value until the next read completes; it is not cleared on writes.
- IDLE/BUSY transfers, or HSEL_APB=0: no state change; the zero-wait OKAY comes from IDLE/DONE.
- Latency (minimum): read = 2 wait states (SETUP, ACCESS); write = 3 (WDATA, SETUP, ACCESS). Each extra PREADY=0 cycle adds one wait state.
- Reset mid-access: PSEL and PENABLE drop immediately (asynchronous); the bridge returns to IDLE with no error reported.

Test Plan:
- Read, PREADY=1 in first ACCESS: NONSEQ read HADDR=0x4000_0010, PRDATA=0xDEAD_BEEF -> PADDR=0x0010, PSEL high 2 cycles, PENABLE high 1 cycle, hready_apb low 2 cycles, then hrdata_apb=0xDEAD_BEEF with OKAY.
- Write with 3 extra PREADY=0 cycles: HADDR=0x4000_0004, HWDATA=0x1234_5678 -> PWRITE=1, PWDATA=0x1234_5678 stable throughout, ACCESS lasts 4 cycles, hready_apb low 6 cycles total.
- PSLVERR=1 with PREADY=1 -> hresp_apb=01 for 2 cycles, hready_apb 0 then 1; PSEL drops after ACCESS.
- TIMEOUT_CYCLES=4, PREADY stuck 0 -> 4 ACCESS cycles, PSEL/PENABLE drop, two-cycle ERROR.
- HSIZE=3'b011 -> no PSEL pulse, two-cycle ERROR. Back-to-back read then write accepted in DONE -> write goes straight to WDATA with no IDLE gap.
- Assert HRESETn=0 during ACCESS -> PSEL=0, PENABLE=0, hready_apb=1 the same cycle; after release, the next read completes normally.

Source files
------------

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave that turns single AHB transfers into APB3 accesses.
// Inserts wait states while APB runs; PSLVERR, timeout or bad HSIZE yield a two-cycle ERROR.
module ahb_apb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int APB_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL_APB,
    input  logic [ADDR_WIDTH-1:0]     HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [DATA_WIDTH-1:0]     HWDATA,
    input  logic                      HREADY,
    output logic [DATA_WIDTH-1:0]     hrdata_apb,
    output logic                      hready_apb,
    output logic [1:0]                hresp_apb,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH-1:0]     PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    output logic [2:0]                o_dbg_state
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_DONE   = 3'd4,
        S_ERR1   = 3'd5,
        S_ERR2   = 3'd6
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [CW-1:0]             r_cnt;
    logic [APB_ADDR_WIDTH-1:0] r_addr;
    logic                      r_write;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      w_accept;
    logic                      w_timeout;
    logic                      w_unused;

    assign w_unused = ^{HADDR[ADDR_WIDTH-1:APB_ADDR_WIDTH], HTRANS[0]};

    always_comb begin
        w_accept  = HSEL_APB & HTRANS[1] & HREADY &
                    ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR2));
        w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1)) && !PREADY;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR2: begin
                w_next = S_IDLE;
                if (w_accept) begin
                    if (HSIZE > 3'b010) w_next = S_ERR1;
                    else if (HWRITE)    w_next = S_WDATA;
                    else                w_next = S_SETUP;
                end
            end
            S_WDATA:  w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: begin
                if (PREADY)         w_next = PSLVERR ? S_ERR1 : S_DONE;
                else if (w_timeout) w_next = S_ERR1;
            end
            S_ERR1:   w_next = S_ERR2;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Counter counts ACCESS cycles already spent; cleared whenever ACCESS is left.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt <= '0;
        end else if (r_state == S_ACCESS) begin
            if (w_next != S_ACCESS) r_cnt <= '0;
            else                    r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= HADDR[APB_ADDR_WIDTH-1:0];
                r_write <= HWRITE;
            end
            if (r_state == S_WDATA) r_wdata <= HWDATA;
            if ((r_state == S_ACCESS) && PREADY && !PSLVERR && !r_write) r_rdata <= PRDATA;
        end
    end

    // Bus controls decode straight from state so an async reset drops them at once.
    always_comb begin
        PSEL        = (r_state == S_SETUP) || (r_state == S_ACCESS);
        PENABLE     = (r_state == S_ACCESS);
        hready_apb  = !((r_state == S_WDATA) || (r_state == S_SETUP) ||
                        (r_state == S_ACCESS) || (r_state == S_ERR1));
        hresp_apb   = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;
        PADDR       = r_addr;
        PWRITE      = r_write;
        PWDATA      = r_wdata;
        hrdata_apb  = r_rdata;
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Randomized scoreboard bench for ahb_apb_bridge: driver pushes expected AHB/APB results,
// independent monitors pop and compare; a behavioural APB slave supplies PREADY/PSLVERR/PRDATA.
module tb_ahb_apb_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int PAW = 16;
    localparam int TO  = 4;

    logic           HCLK = 1'b0;
    logic           HRESETn;
    logic           HSEL_APB;
    logic [AW-1:0]  HADDR;
    logic [1:0]     HTRANS;
    logic           HWRITE;
    logic [2:0]     HSIZE;
    logic [DW-1:0]  HWDATA;
    logic [DW-1:0]  hrdata_apb;
    logic           hready_apb;
    logic [1:0]     hresp_apb;
    logic [PAW-1:0] PADDR;
    logic           PSEL;
    logic           PENABLE;
    logic           PWRITE;
    logic [DW-1:0]  PWDATA;
    logic [DW-1:0]  PRDATA;
    logic           PREADY;
    logic           PSLVERR;
    logic [2:0]     dbg_state;

    always #5 HCLK = ~HCLK;

    ahb_apb_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .APB_ADDR_WIDTH(PAW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL_APB(HSEL_APB), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(hready_apb), .hrdata_apb(hrdata_apb), .hready_apb(hready_apb),
        .hresp_apb(hresp_apb), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .o_dbg_state(dbg_state)
    );

    typedef struct { logic write; logic err; logic [DW-1:0] rdata; int waits; } ahb_exp_t;
    typedef struct { logic [PAW-1:0] addr; logic write; logic [DW-1:0] wdata; int acc; } apb_exp_t;
    typedef struct { int waits; logic err; logic [DW-1:0] rdata; } slv_cfg_t;

    ahb_exp_t ahb_q[$];
    apb_exp_t apb_q[$];
    slv_cfg_t slv_q[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] model_rd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural APB slave: PREADY rises after cfg.waits stalled ACCESS cycles.
    slv_cfg_t s_cfg;
    int       s_cnt;
    bit       s_active;
    always @(posedge HCLK) begin
        #1;
        if (!HRESETn) begin
            PREADY = 1'b0; PSLVERR = 1'b0; s_active = 1'b0;
        end else if (PSEL && !PENABLE) begin
            s_active = (slv_q.size() > 0);
            if (s_active) s_cfg = slv_q.pop_front();
            s_cnt  = 0;
            PREADY = 1'b0;
        end else if (PSEL && PENABLE && s_active) begin
            PREADY  = (s_cnt == s_cfg.waits);
            PSLVERR = PREADY ? s_cfg.err : 1'($urandom_range(0, 1));
            PRDATA  = PREADY ? s_cfg.rdata : $urandom;
            s_cnt++;
        end else begin
            PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
        end
    end

    // AHB monitor: measures wait states of each data phase and checks the response.
    bit       m_active = 0;
    int       m_waits;
    logic [1:0] m_prev;
    ahb_exp_t m_e;
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            m_active = 0;
        end else begin
            if (m_active) begin
                if (!hready_apb) begin
                    m_waits++;
                    m_prev = hresp_apb;
                end else begin
                    if (ahb_q.size() == 0) begin
                        check("ahb_unexpected_completion", 1, 0);
                    end else begin
                        m_e = ahb_q.pop_front();
                        check("ahb_wait_states", 64'(m_waits), 64'(m_e.waits));
                        check("ahb_hresp", 64'(hresp_apb), m_e.err ? 64'd1 : 64'd0);
                        if (m_e.err) check("ahb_err_first_cycle", 64'(m_prev), 64'd1);
                        if (!m_e.write && !m_e.err) model_rd = m_e.rdata;
                        check("ahb_hrdata", 64'(hrdata_apb), 64'(model_rd));
                    end
                    m_active = 0;
                end
            end
            if (HSEL_APB && HTRANS[1] && hready_apb) begin
                m_active = 1; m_waits = 0; m_prev = 2'b00;
            end
        end
    end

    // APB monitor: checks SETUP contents, stability during ACCESS and ACCESS length.
    apb_exp_t p_cur;
    bit       p_in = 0;
    int       p_acc;
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            p_in = 0;
        end else if (PSEL && !PENABLE) begin
            if (apb_q.size() == 0) begin
                check("apb_spurious_access", 1, 0);
                p_in = 0;
            end else begin
                p_cur = apb_q.pop_front();
                check("apb_paddr", 64'(PADDR), 64'(p_cur.addr));
                check("apb_pwrite", 64'(PWRITE), 64'(p_cur.write));
                if (p_cur.write) check("apb_pwdata", 64'(PWDATA), 64'(p_cur.wdata));
                p_acc = 0;
                p_in  = 1;
            end
        end else if (PSEL && PENABLE) begin
            p_acc++;
            if (p_in) begin
                check("apb_paddr_stable", 64'(PADDR), 64'(p_cur.addr));
                if (p_cur.write) check("apb_pwdata_stable", 64'(PWDATA), 64'(p_cur.wdata));
            end
        end else if (p_in) begin
            check("apb_access_cycles", 64'(p_acc), 64'(p_cur.acc));
            p_in = 0;
        end
    end

    // Issue one address phase; expectations follow from the transfer rules, not the RTL.
    task automatic issue(input logic [AW-1:0] addr, input logic wr, input logic [2:0] size,
                         input logic [DW-1:0] wdata, input int w, input logic err,
                         input logic [DW-1:0] rdata);
        ahb_exp_t e;
        apb_exp_t a;
        slv_cfg_t c;
        bit ok, to, rdy;
        int acc, guard;
        ok  = (size <= 3'd2);
        to  = (TO != 0) && (w >= TO);
        acc = to ? TO : w + 1;
        e.write = wr;
        e.err   = !ok || to || err;
        e.rdata = rdata;
        e.waits = ok ? ((wr ? 1 : 0) + 1 + acc + (e.err ? 1 : 0)) : 1;
        if (ok) begin
            a = '{addr[PAW-1:0], wr, wdata, acc};
            apb_q.push_back(a);
            c = '{w, err, rdata};
            slv_q.push_back(c);
        end
        ahb_q.push_back(e);
        HSEL_APB = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
        guard = 0;
        do begin
            @(negedge HCLK); rdy = hready_apb;
            @(posedge HCLK); guard++;
        end while (!rdy && guard < 100);
        if (!rdy) check("ahb_accept_timeout", 0, 1);
        #1;
        HSEL_APB = 1'($urandom_range(0, 1)); HTRANS = 2'b00;
        HADDR = $urandom; HWRITE = 1'($urandom_range(0, 1)); HSIZE = 3'($urandom_range(0, 7));
        HWDATA = wr ? wdata : $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            HSEL_APB = 1'($urandom_range(0, 1)); HTRANS = 2'($urandom_range(0, 1));
            HADDR = $urandom; HWRITE = 1'($urandom_range(0, 1));
            @(posedge HCLK); #1;
        end
        HSEL_APB = 1'b0; HTRANS = 2'b00;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((ahb_q.size() != 0 || apb_q.size() != 0 || m_active) && guard < 200) begin
            @(negedge HCLK); guard++;
        end
        if (guard >= 200) check("drain_timeout", 0, 1);
        @(posedge HCLK); #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_psel", 64'(PSEL), 0);
        check("rst_penable", 64'(PENABLE), 0);
        check("rst_hready", 64'(hready_apb), 1);
        check("rst_hresp", 64'(hresp_apb), 0);
        check("rst_hrdata", 64'(hrdata_apb), 0);
        check("rst_paddr", 64'(PADDR), 0);
        check("rst_pwrite", 64'(PWRITE), 0);
        check("rst_pwdata", 64'(PWDATA), 0);
    endtask

    initial begin
        int guard;
        logic [2:0] sz;
        int w;
        HRESETn = 1'b0; HSEL_APB = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'd2; HWDATA = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        check_reset_outputs();
        HRESETn = 1'b1;
        idle(2);

        issue(32'h4000_0010, 1'b0, 3'd2, '0, 0, 1'b0, 32'hDEAD_BEEF);
        drain();
        issue(32'h4000_0004, 1'b1, 3'd2, 32'h1234_5678, 3, 1'b0, '0);
        drain();
        issue(32'h4000_0020, 1'b0, 3'd2, '0, 0, 1'b1, 32'hCAFE_0001);
        drain();
        issue(32'h4000_0030, 1'b0, 3'd1, '0, 100, 1'b0, 32'h0BAD_0BAD);
        drain();
        issue(32'h4000_0040, 1'b0, 3'd3, '0, 0, 1'b0, 32'h5555_AAAA);
        drain();
        issue(32'h4000_0050, 1'b0, 3'd2, '0, 1, 1'b0, 32'hA5A5_1234);
        issue(32'h4000_0054, 1'b1, 3'd0, 32'h8765_4321, 0, 1'b0, '0);
        drain();

        issue(32'h4000_0060, 1'b0, 3'd2, '0, 3, 1'b0, 32'h7777_7777);
        guard = 0;
        do begin @(negedge HCLK); guard++; end while (!PENABLE && guard < 50);
        HRESETn = 1'b0;
        #1;
        check("midrst_psel", 64'(PSEL), 0);
        check("midrst_penable", 64'(PENABLE), 0);
        check("midrst_hready", 64'(hready_apb), 1);
        check("midrst_hresp", 64'(hresp_apb), 0);
        ahb_q.delete(); apb_q.delete(); slv_q.delete();
        model_rd = '0;
        repeat (2) @(posedge HCLK);
        #1;
        check("midrst_hrdata", 64'(hrdata_apb), 0);
        HRESETn = 1'b1;
        idle(1);
        issue(32'h4000_0070, 1'b0, 3'd2, '0, 0, 1'b0, 32'h0123_4567);
        drain();

        for (int i = 0; i < 60; i++) begin
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            w  = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 8) : $urandom_range(0, 3);
            issue($urandom, 1'($urandom_range(0, 1)), sz, $urandom, w,
                  ($urandom_range(0, 4) == 0), $urandom);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
